// File: rtl/binary_to_gray_counter_pkg.sv
// Shared constants and helpers for the binary/Gray up-down counter.
// Optional parallel load is enabled by defining GRAY_CNT_LOAD_EN.
package binary_to_gray_counter_pkg;

  localparam int GRAY_CNT_WIDTH = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic [GRAY_CNT_WIDTH-1:0] bin2gray(
    input logic [GRAY_CNT_WIDTH-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/binary_to_gray_counter_if.sv
// Control/status bundle between a counter user and the counter.
// load/load_bin exist only when GRAY_CNT_LOAD_EN is defined.
interface binary_to_gray_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             dir;
`ifdef GRAY_CNT_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] load_bin;
`endif
  logic [WIDTH-1:0] out_binary;
  logic [WIDTH-1:0] out_gray;
  logic             wrap;

`ifdef GRAY_CNT_LOAD_EN
  modport master (
    output en, dir, load, load_bin,
    input  out_binary, out_gray, wrap
  );
  modport slave (
    input  en, dir, load, load_bin,
    output out_binary, out_gray, wrap
  );
`else
  modport master (
    output en, dir,
    input  out_binary, out_gray, wrap
  );
  modport slave (
    input  en, dir,
    output out_binary, out_gray, wrap
  );
`endif

endinterface

// File: rtl/binary_to_gray_counter_enc.sv
// Combinational binary to reflected-Gray encoder.
// Inverse of the Gray-to-binary decoder.
module binary_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/binary_to_gray_counter.sv
// Registered up/down counter with binary and Gray outputs.
// Define GRAY_CNT_LOAD_EN to add a parallel load (priority over en).
module binary_to_gray_counter
  import binary_to_gray_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_CNT_WIDTH
) (
  input logic                     clk,
  input logic                     rst_n,
  binary_to_gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  =
    {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_next_wrap;

  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
`ifdef GRAY_CNT_LOAD_EN
    if (bus.load) begin
      w_next_bin = bus.load_bin;
    end else
`endif
    if (bus.en) begin
      if (bus.dir == DIR_UP) begin
        w_next_bin  = r_bin + ONE;
        w_next_wrap = (r_bin == ONES);
      end else begin
        w_next_bin  = r_bin - ONE;
        w_next_wrap = (r_bin == ZERO);
      end
    end
  end

  // Gray is always re-encoded from the next binary, never stepped itself
  binary_to_gray #(
    .WIDTH (WIDTH)
  ) u_enc (
    .i_bin  (w_next_bin),
    .o_gray (w_next_gray)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_wrap <= w_next_wrap;
    end
  end

  assign bus.out_binary = r_bin;
  assign bus.out_gray   = r_gray;
  assign bus.wrap       = r_wrap;

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// Self-checking bench for binary_to_gray_counter (WIDTH=4).
// Load cases run only when GRAY_CNT_LOAD_EN is defined.
module tb_binary_to_gray_counter;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_fail;

  int          m_cnt;
  logic        m_wrap;
  logic [3:0]  prev_gray;
  logic [3:0]  gray_tab [16];

  binary_to_gray_counter_if #(.WIDTH(4)) bus ();

  binary_to_gray_counter #(
    .WIDTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".bin"},  bus.out_binary, m_cnt[3:0]);
    chk({tag, ".gray"}, bus.out_gray, gray_tab[m_cnt]);
    chk({tag, ".wrap"}, bus.wrap, m_wrap);
    chk({tag, ".rt"},   g2b(bus.out_gray), bus.out_binary);
  endtask

  // Called at a negedge; applies inputs for one edge, checks at next negedge
  task automatic cyc(input string tag, input logic e, input logic d,
                     input logic l, input logic [3:0] lb);
    logic stepped;
    bus.en  = e;
    bus.dir = d;
`ifdef GRAY_CNT_LOAD_EN
    bus.load     = l;
    bus.load_bin = lb;
`else
    stepped = l ^ (|lb);
`endif
    prev_gray = bus.out_gray;
    @(posedge clk);
    stepped = 1'b0;
`ifdef GRAY_CNT_LOAD_EN
    if (l) begin
      m_cnt  = int'(lb);
      m_wrap = 1'b0;
    end else
`endif
    if (e) begin
      stepped = 1'b1;
      if (d) begin
        m_wrap = (m_cnt == 15);
        m_cnt  = (m_cnt + 1) % 16;
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt  = (m_cnt + 15) % 16;
      end
    end else begin
      m_wrap = 1'b0;
    end
    @(negedge clk);
    check_all(tag);
    if (stepped)
      chk({tag, ".1bit"},
          $countones(prev_gray ^ bus.out_gray), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cnt = 0;
    m_wrap = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    n_chk  = 0;
    n_fail = 0;
    m_cnt  = 0;
    m_wrap = 1'b0;
    rst_n  = 1'b0;
    bus.en  = 1'b0;
    bus.dir = 1'b1;
`ifdef GRAY_CNT_LOAD_EN
    bus.load     = 1'b0;
    bus.load_bin = '0;
`endif
    #1;
    check_all("rst0");

    // reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      bus.en  = 1'b1;
      bus.dir = i[0];
      @(negedge clk);
      check_all("rst_hold");
    end
    rst_n = 1'b1;

    // full up sweep with wrap
    for (int i = 0; i < 16; i++) cyc("up", 1'b1, 1'b1, 1'b0, 4'h0);

    // async reset between edges mid-count
    cyc("pre", 1'b1, 1'b1, 1'b0, 4'h0);
    cyc("pre", 1'b1, 1'b1, 1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    m_cnt = 0;
    m_wrap = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // down wrap from reset
    cyc("dn_wrap", 1'b1, 1'b0, 1'b0, 4'h0);
    cyc("dn_next", 1'b1, 1'b0, 1'b0, 4'h0);

    // hold at 0101 while dir toggles
    do_reset();
    for (int i = 0; i < 5; i++) cyc("to5", 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) cyc("hold", 1'b0, i[0], 1'b0, 4'h0);

`ifdef GRAY_CNT_LOAD_EN
    cyc("load", 1'b1, 1'b1, 1'b1, 4'b1010);
    cyc("ld_step", 1'b1, 1'b0, 1'b0, 4'h0);
    cyc("ld_ones", 1'b0, 1'b0, 1'b1, 4'hf);
    cyc("ld_wrap", 1'b1, 1'b1, 1'b0, 4'h0);
`endif

    // random en/dir (and load) sequence
    for (int i = 0; i < 300; i++) begin
      logic e, d, l;
      logic [3:0] lb;
      e  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1) == 1;
      l  = ($urandom_range(0, 15) == 0);
      lb = 4'($urandom_range(0, 15));
`ifndef GRAY_CNT_LOAD_EN
      l  = 1'b0;
      lb = 4'h0;
`endif
      cyc("rand", e, d, l, lb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
